sdmp3_checker: RTL and testbench

Parametrised bench-side stream checker for SD-to-MP3 streaming tests, running on the FPGA clock. It oversamples the SD SPI card-to-host line and the MP3 serial data port, deserialises both into bytes, and queues the SD bytes as expected data. Each MP3 byte is compared in order against that queue, and the block reports counts and errors. It also models the decoder's DREQ flow control with a programmable drain rate, which a fixed-behaviour MP3 model cannot do.

---
 rtl/sdmp3_checker.sv | 214 +++++++++++++++++++++
 tb/tb_sdmp3_checker.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdmp3_checker.sv
// sdmp3_checker: oversampling SD/MP3 serial stream checker.
// SD bytes queue as expected data; MP3 bytes are compared in order.
module sdmp3_checker #(
  parameter int DEPTH         = 512,
  parameter int REQ_THR       = 32,
  parameter int DRAIN_DIV     = 64,
  parameter bit MP3_LSB_FIRST = 1'b0,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          sd_clk,
  input  logic          sd_cs,
  input  logic          sd_dat,
  input  logic          cap_en,
  input  logic          mp3_clk,
  input  logic          mp3_dat,
  input  logic          mp3_sync,
  output logic          mp3_req,
  output logic [AW:0]   level,
  output logic [31:0]   cmp_cnt,
  output logic [15:0]   err_cnt,
  output logic [7:0]    first_exp,
  output logic [7:0]    first_got,
  output logic          ovf,
  output logic          unf
);

  localparam int DW = (DRAIN_DIV > 1) ? $clog2(DRAIN_DIV) : 1;

  logic [5:0]    raw;
  logic [5:0]    s1_q, s2_q, s3_q;
  logic          sd_rise_q, sd_rise_d;
  logic          mp_rise_q, mp_rise_d;
  logic [7:0]    sd_sh_q, sd_sh_d;
  logic [2:0]    sd_cnt_q, sd_cnt_d;
  logic          sd_stb_q, sd_stb_d;
  logic [7:0]    mp_sh_q, mp_sh_d;
  logic [2:0]    mp_cnt_q, mp_cnt_d;
  logic          mp_stb_q, mp_stb_d;
  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [AW:0]   level_q, level_d;
  logic [31:0]   cmp_q, cmp_d;
  logic [15:0]   err_q, err_d;
  logic [7:0]    fe_q, fe_d, fg_q, fg_d;
  logic          seen_q, seen_d;
  logic          ovf_q, ovf_d, unf_q, unf_d;
  logic [DW-1:0] div_q, div_d;
  logic [7:0]    pend_q, pend_d;
  logic          req_q, req_d;
  logic          full, empty, push, pop, push_ok, pop_ok;
  logic          tick, inc, dec;
  logic [7:0]    head;

  assign raw = {mp3_sync, mp3_dat, mp3_clk, sd_dat, sd_cs, sd_clk};

  // Rising-edge detect on both serial clocks, aligned with the 3rd sync flop
  always_comb begin
    sd_rise_d = s2_q[0] & ~s3_q[0];
    mp_rise_d = s2_q[3] & ~s3_q[3];
  end

  // SD deserialiser; chip-select high drops any partial byte
  always_comb begin
    sd_sh_d  = sd_sh_q;
    sd_cnt_d = sd_cnt_q;
    sd_stb_d = 1'b0;
    if (s3_q[1]) begin
      sd_sh_d  = '0;
      sd_cnt_d = '0;
    end else if (sd_rise_q) begin
      sd_sh_d  = {sd_sh_q[6:0], s3_q[2]};
      sd_cnt_d = sd_cnt_q + 3'd1;
      sd_stb_d = (sd_cnt_q == 3'd7);
    end
  end

  // MP3 deserialiser; sync marks bit 1 of a new byte
  always_comb begin
    mp_sh_d  = mp_sh_q;
    mp_cnt_d = mp_cnt_q;
    mp_stb_d = 1'b0;
    if (mp_rise_q) begin
      mp_sh_d = MP3_LSB_FIRST ? {s3_q[4], mp_sh_q[7:1]}
                              : {mp_sh_q[6:0], s3_q[4]};
      if (s3_q[5]) begin
        mp_cnt_d = 3'd1;
      end else begin
        mp_cnt_d = mp_cnt_q + 3'd1;
        mp_stb_d = (mp_cnt_q == 3'd7);
      end
    end
  end

  assign full    = (level_q == (AW+1)'(DEPTH));
  assign empty   = (level_q == '0);
  assign push    = sd_stb_q & cap_en;
  assign pop     = mp_stb_q;
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign head    = mem_q[rp_q];

  // FIFO pointers, compare counters and sticky flags
  always_comb begin
    wp_d    = wp_q;
    rp_d    = rp_q;
    level_d = level_q;
    cmp_d   = cmp_q;
    err_d   = err_q;
    fe_d    = fe_q;
    fg_d    = fg_q;
    seen_d  = seen_q;
    ovf_d   = ovf_q | (push & full);
    unf_d   = unf_q | (pop & empty);
    if (push_ok) wp_d = wp_q + AW'(1);
    if (pop_ok) rp_d = rp_q + AW'(1);
    if (push_ok && !pop_ok) level_d = level_q + (AW+1)'(1);
    if (pop_ok && !push_ok) level_d = level_q - (AW+1)'(1);
    if (pop_ok) begin
      cmp_d = cmp_q + 32'd1;
      if (head != mp_sh_q) begin
        if (err_q != 16'hFFFF) err_d = err_q + 16'd1;
        if (!seen_q) begin
          seen_d = 1'b1;
          fe_d   = head;
          fg_d   = mp_sh_q;
        end
      end
    end
  end

  // Decoder buffer: fills per MP3 byte, drains one byte per divider tick
  always_comb begin
    tick   = (div_q == DW'(DRAIN_DIV - 1));
    div_d  = tick ? '0 : div_q + DW'(1);
    inc    = mp_stb_q;
    dec    = tick & (pend_q != 8'd0);
    pend_d = pend_q;
    if (inc && !dec && pend_q != 8'hFF) pend_d = pend_q + 8'd1;
    if (dec && !inc) pend_d = pend_q - 8'd1;
    req_d  = (pend_q < 8'(REQ_THR));
  end

  // Expected-byte storage, no reset needed
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wp_q] <= sd_sh_q;
  end

  // State registers
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q      <= '0;
      s2_q      <= '0;
      s3_q      <= '0;
      sd_rise_q <= 1'b0;
      mp_rise_q <= 1'b0;
      sd_sh_q   <= '0;
      sd_cnt_q  <= '0;
      sd_stb_q  <= 1'b0;
      mp_sh_q   <= '0;
      mp_cnt_q  <= '0;
      mp_stb_q  <= 1'b0;
      wp_q      <= '0;
      rp_q      <= '0;
      level_q   <= '0;
      cmp_q     <= '0;
      err_q     <= '0;
      fe_q      <= '0;
      fg_q      <= '0;
      seen_q    <= 1'b0;
      ovf_q     <= 1'b0;
      unf_q     <= 1'b0;
      div_q     <= '0;
      pend_q    <= '0;
      req_q     <= 1'b1;
    end else begin
      s1_q      <= raw;
      s2_q      <= s1_q;
      s3_q      <= s2_q;
      sd_rise_q <= sd_rise_d;
      mp_rise_q <= mp_rise_d;
      sd_sh_q   <= sd_sh_d;
      sd_cnt_q  <= sd_cnt_d;
      sd_stb_q  <= sd_stb_d;
      mp_sh_q   <= mp_sh_d;
      mp_cnt_q  <= mp_cnt_d;
      mp_stb_q  <= mp_stb_d;
      wp_q      <= wp_d;
      rp_q      <= rp_d;
      level_q   <= level_d;
      cmp_q     <= cmp_d;
      err_q     <= err_d;
      fe_q      <= fe_d;
      fg_q      <= fg_d;
      seen_q    <= seen_d;
      ovf_q     <= ovf_d;
      unf_q     <= unf_d;
      div_q     <= div_d;
      pend_q    <= pend_d;
      req_q     <= req_d;
    end
  end

  assign mp3_req   = req_q;
  assign level     = level_q;
  assign cmp_cnt   = cmp_q;
  assign err_cnt   = err_q;
  assign first_exp = fe_q;
  assign first_got = fg_q;
  assign ovf       = ovf_q;
  assign unf       = unf_q;

endmodule

// File: tb/tb_sdmp3_checker.sv
// tb_sdmp3_checker: table, directed and random checks of sdmp3_checker.
// Three instances share stimulus: default, DEPTH=4, slow-drain DREQ.
`timescale 1ns/1ps
module tb_sdmp3_checker;

  logic clk, rst;
  logic sd_clk, sd_cs, sd_dat, cap_en;
  logic mp3_clk, mp3_dat, mp3_sync;

  logic        a_req, b_req, c_req;
  logic [9:0]  a_level;
  logic [2:0]  b_level;
  logic [4:0]  c_level;
  logic [31:0] a_cmp, b_cmp, c_cmp;
  logic [15:0] a_err, b_err, c_err;
  logic [7:0]  a_fe, a_fg, b_fe, b_fg, c_fe, c_fg;
  logic        a_ovf, a_unf, b_ovf, b_unf, c_ovf, c_unf;

  sdmp3_checker u_a (
    .clk(clk), .rst(rst), .sd_clk(sd_clk), .sd_cs(sd_cs),
    .sd_dat(sd_dat), .cap_en(cap_en), .mp3_clk(mp3_clk),
    .mp3_dat(mp3_dat), .mp3_sync(mp3_sync), .mp3_req(a_req),
    .level(a_level), .cmp_cnt(a_cmp), .err_cnt(a_err),
    .first_exp(a_fe), .first_got(a_fg), .ovf(a_ovf), .unf(a_unf)
  );

  sdmp3_checker #(.DEPTH(4), .REQ_THR(4), .DRAIN_DIV(100)) u_b (
    .clk(clk), .rst(rst), .sd_clk(sd_clk), .sd_cs(sd_cs),
    .sd_dat(sd_dat), .cap_en(cap_en), .mp3_clk(mp3_clk),
    .mp3_dat(mp3_dat), .mp3_sync(mp3_sync), .mp3_req(b_req),
    .level(b_level), .cmp_cnt(b_cmp), .err_cnt(b_err),
    .first_exp(b_fe), .first_got(b_fg), .ovf(b_ovf), .unf(b_unf)
  );

  sdmp3_checker #(.DEPTH(16), .REQ_THR(4), .DRAIN_DIV(1000)) u_c (
    .clk(clk), .rst(rst), .sd_clk(sd_clk), .sd_cs(sd_cs),
    .sd_dat(sd_dat), .cap_en(cap_en), .mp3_clk(mp3_clk),
    .mp3_dat(mp3_dat), .mp3_sync(mp3_sync), .mp3_req(c_req),
    .level(c_level), .cmp_cnt(c_cmp), .err_cnt(c_err),
    .first_exp(c_fe), .first_got(c_fg), .ovf(c_ovf), .unf(c_unf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  int unsigned b_low_cyc = 0;
  always @(posedge clk) if (!b_req) b_low_cyc <= b_low_cyc + 1;

  // reference model: byte-level queues for instances A (512) and B (4)
  logic [7:0]  mq0[$];
  logic [7:0]  mq1[$];
  int          md[2] = '{512, 4};
  int unsigned mcmp[2];
  int unsigned merr[2];
  logic [7:0]  mfe[2], mfg[2];
  bit          mseen[2], movf[2], munf[2];

  function automatic int qsize(input int k);
    return (k == 0) ? mq0.size() : mq1.size();
  endfunction

  task automatic m_reset();
    mq0.delete();
    mq1.delete();
    for (int k = 0; k < 2; k++) begin
      mcmp[k] = 0; merr[k] = 0; mfe[k] = 0; mfg[k] = 0;
      mseen[k] = 0; movf[k] = 0; munf[k] = 0;
    end
  endtask

  task automatic m_push(input logic [7:0] b);
    for (int k = 0; k < 2; k++) begin
      if (qsize(k) == md[k]) movf[k] = 1;
      else if (k == 0) mq0.push_back(b);
      else mq1.push_back(b);
    end
  endtask

  task automatic m_pop(input logic [7:0] b);
    logic [7:0] h;
    for (int k = 0; k < 2; k++) begin
      if (qsize(k) == 0) begin
        munf[k] = 1;
      end else begin
        if (k == 0) h = mq0.pop_front();
        else h = mq1.pop_front();
        mcmp[k]++;
        if (h != b) begin
          if (merr[k] < 65535) merr[k]++;
          if (!mseen[k]) begin
            mseen[k] = 1; mfe[k] = h; mfg[k] = b;
          end
        end
      end
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic check_all(input string t);
    chk({t, "_a_level"}, 32'(a_level), 32'(mq0.size()));
    chk({t, "_a_cmp"}, a_cmp, mcmp[0]);
    chk({t, "_a_err"}, 32'(a_err), merr[0]);
    chk({t, "_a_fe"}, 32'(a_fe), 32'(mfe[0]));
    chk({t, "_a_fg"}, 32'(a_fg), 32'(mfg[0]));
    chk({t, "_a_ovf"}, 32'(a_ovf), 32'(movf[0]));
    chk({t, "_a_unf"}, 32'(a_unf), 32'(munf[0]));
    chk({t, "_b_level"}, 32'(b_level), 32'(mq1.size()));
    chk({t, "_b_cmp"}, b_cmp, mcmp[1]);
    chk({t, "_b_err"}, 32'(b_err), merr[1]);
    chk({t, "_b_fe"}, 32'(b_fe), 32'(mfe[1]));
    chk({t, "_b_fg"}, 32'(b_fg), 32'(mfg[1]));
    chk({t, "_b_ovf"}, 32'(b_ovf), 32'(movf[1]));
    chk({t, "_b_unf"}, 32'(b_unf), 32'(munf[1]));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1; sd_clk = 0; sd_cs = 1; sd_dat = 0;
    mp3_clk = 0; mp3_dat = 0; mp3_sync = 0; cap_en = 1;
    repeat (4) @(negedge clk);
    rst = 0;
    repeat (4) @(negedge clk);
    m_reset();
  endtask

  task automatic sd_bits(input logic [7:0] b, input int n);
    @(negedge clk);
    sd_cs = 0;
    for (int i = 0; i < n; i++) begin
      sd_dat = b[7-i];
      repeat (4) @(negedge clk);
      sd_clk = 1;
      repeat (4) @(negedge clk);
      sd_clk = 0;
    end
    repeat (2) @(negedge clk);
    sd_cs = 1;
    repeat (8) @(negedge clk);
    if (n == 8 && cap_en) m_push(b);
  endtask

  task automatic mp3_byte(input logic [7:0] b, input int hp,
                          input int post, input bit chk_req);
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      mp3_dat = b[7-i];
      mp3_sync = (i == 0);
      repeat (hp) @(negedge clk);
      mp3_clk = 1;
      if (chk_req && i == 7) begin
        @(posedge clk);
        repeat (4) @(posedge clk);
        #1 chk("c_req_at_e4", 32'(c_req), 1);
        @(posedge clk);
        #1 chk("c_req_at_e5", 32'(c_req), 0);
      end
      repeat (hp) @(negedge clk);
      mp3_clk = 0;
    end
    mp3_sync = 0;
    repeat (post) @(negedge clk);
    m_pop(b);
  endtask

  typedef struct {
    logic [7:0]  sd;
    logic        cap;
    logic [7:0]  mp;
    logic [31:0] cmp;
    logic [15:0] err;
    logic        unf;
  } vec_t;

  vec_t tbl[5];

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [7:0] b;
    int unsigned base;
    int r;
    tbl[0] = '{8'h11, 1'b1, 8'h11, 32'd1, 16'd0, 1'b0};
    tbl[1] = '{8'h22, 1'b1, 8'h23, 32'd2, 16'd1, 1'b0};
    tbl[2] = '{8'h33, 1'b0, 8'h33, 32'd2, 16'd1, 1'b1};
    tbl[3] = '{8'h80, 1'b1, 8'h80, 32'd3, 16'd1, 1'b1};
    tbl[4] = '{8'hFF, 1'b1, 8'h00, 32'd4, 16'd2, 1'b1};

    rst = 1; sd_clk = 0; sd_cs = 1; sd_dat = 0; cap_en = 1;
    mp3_clk = 0; mp3_dat = 0; mp3_sync = 0;
    do_reset();
    check_all("reset");
    chk("reset_a_req", 32'(a_req), 1);
    chk("reset_b_req", 32'(b_req), 1);
    chk("reset_c_req", 32'(c_req), 1);

    // table vectors
    do_reset();
    for (int i = 0; i < 5; i++) begin
      cap_en = tbl[i].cap;
      sd_bits(tbl[i].sd, 8);
      mp3_byte(tbl[i].mp, 4, 8, 0);
      chk("tbl_cmp", a_cmp, tbl[i].cmp);
      chk("tbl_err", 32'(a_err), 32'(tbl[i].err));
      chk("tbl_unf", 32'(a_unf), 32'(tbl[i].unf));
      chk("tbl_level", 32'(a_level), 0);
    end
    cap_en = 1;
    chk("tbl_fe", 32'(a_fe), 32'h22);
    chk("tbl_fg", 32'(a_fg), 32'h23);
    check_all("tbl");

    // 16 matching bytes
    do_reset();
    for (int i = 0; i < 16; i++) sd_bits(8'(i), 8);
    for (int i = 0; i < 16; i++) mp3_byte(8'(i), 4, 8, 0);
    chk("t1_cmp", a_cmp, 16);
    chk("t1_err", 32'(a_err), 0);
    check_all("t1");

    // two corrupted bytes
    do_reset();
    for (int i = 0; i < 16; i++) sd_bits(8'(i), 8);
    for (int i = 0; i < 16; i++) begin
      b = 8'(i);
      if (i == 5) b = 8'hA5;
      if (i == 9) b = 8'hFF;
      mp3_byte(b, 4, 8, 0);
    end
    chk("t2_err", 32'(a_err), 2);
    chk("t2_fe", 32'(a_fe), 32'h05);
    chk("t2_fg", 32'(a_fg), 32'hA5);
    check_all("t2");

    // overflow on the 4-deep instance
    do_reset();
    for (int i = 0; i < 5; i++) sd_bits(8'hA0 + 8'(i), 8);
    chk("t3_b_ovf", 32'(b_ovf), 1);
    chk("t3_b_level", 32'(b_level), 4);
    for (int i = 0; i < 4; i++) mp3_byte(8'hA0 + 8'(i), 4, 8, 0);
    chk("t3_b_err", 32'(b_err), 0);
    chk("t3_b_cmp", b_cmp, 4);
    check_all("t3");

    // underflow
    do_reset();
    mp3_byte(8'h5A, 4, 8, 0);
    chk("t4_unf", 32'(a_unf), 1);
    chk("t4_cmp", a_cmp, 0);
    check_all("t4");

    // partial SD byte discarded by chip-select
    do_reset();
    sd_bits(8'hFF, 3);
    sd_bits(8'h3C, 8);
    chk("t6_level", 32'(a_level), 1);
    mp3_byte(8'h3C, 4, 8, 0);
    chk("t6_err", 32'(a_err), 0);
    chk("t6_cmp", a_cmp, 1);
    check_all("t6");

    // DREQ exact latency on the slow-drain instance
    do_reset();
    for (int i = 0; i < 3; i++) mp3_byte(8'(i), 4, 2, 0);
    repeat (4) @(negedge clk);
    chk("c_req_pend3", 32'(c_req), 1);
    mp3_byte(8'h03, 4, 2, 1);
    for (int i = 0; i < 1200; i++) begin
      if (c_req) break;
      @(negedge clk);
    end
    chk("c_req_recover", 32'(c_req), 1);

    // DREQ burst on DRAIN_DIV=100 instance
    do_reset();
    base = b_low_cyc;
    for (int i = 0; i < 6; i++) mp3_byte(8'(i), 2, 0, 0);
    repeat (6) @(negedge clk);
    chk("b_req_low_seen", 32'(b_low_cyc != base), 1);
    for (int i = 0; i < 600; i++) begin
      if (b_req) break;
      @(negedge clk);
    end
    chk("b_req_recover", 32'(b_req), 1);
    check_all("dreq");

    // randomized traffic against the model
    do_reset();
    for (int i = 0; i < 60; i++) begin
      r = $urandom_range(0, 99);
      if (r < 50) begin
        cap_en = ($urandom_range(0, 9) != 0);
        sd_bits(8'($urandom), 8);
      end else begin
        if (mq0.size() > 0 && $urandom_range(0, 3) != 0) b = mq0[0];
        else b = 8'($urandom);
        mp3_byte(b, $urandom_range(2, 4), 8, 0);
      end
      if (i % 10 == 9) check_all("rnd");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
